// File: rtl/dii_package.sv
// dii_package: debug-interconnect flit type plus register-access packet encodings.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    localparam logic [1:0] TYPE_REG = 2'b00;

    localparam logic [3:0] REQ_READ       = 4'd0;
    localparam logic [3:0] REQ_WRITE      = 4'd1;
    localparam logic [3:0] RESP_READ_OK   = 4'd2;
    localparam logic [3:0] RESP_READ_ERR  = 4'd3;
    localparam logic [3:0] RESP_WRITE_OK  = 4'd4;
    localparam logic [3:0] RESP_WRITE_ERR = 4'd5;

    localparam logic [15:0] ADDR_VENDOR   = 16'h0000;
    localparam logic [15:0] ADDR_TYPE     = 16'h0001;
    localparam logic [15:0] ADDR_VERSION  = 16'h0002;
    localparam logic [15:0] ADDR_EXT_BASE = 16'h0200;

    typedef enum logic [3:0] {
        IDLE, RX_SRC, RX_TYPE, RX_ADDR, RX_WDATA, DRAIN,
        ACCESS, TX_DEST, TX_SRC, TX_TYPE, TX_RDATA
    } state_t;

    function automatic logic [15:0] type_word(input logic [3:0] sub);
        return {TYPE_REG, sub, 10'h000};
    endfunction

endpackage

// File: rtl/osd_regaccess_responder_if.sv
// osd_regaccess_responder_if: address decode lookup between the responder FSM and its base registers.
interface osd_regaccess_responder_if;
    logic [15:0] addr;
    logic        write;
    logic        ext;
    logic        err;
    logic [15:0] rdata;

    modport master (output addr, write, input ext, err, rdata);
    modport slave  (input addr, write, output ext, err, rdata);
endinterface

// File: rtl/osd_regaccess_baseregs.sv
// osd_regaccess_baseregs: read-only module identification registers below the host window.
module osd_regaccess_baseregs
    import dii_package::*;
#(
    parameter logic [15:0] MOD_VENDOR  = 16'h0,
    parameter logic [15:0] MOD_TYPE    = 16'h0,
    parameter logic [15:0] MOD_VERSION = 16'h0
) (
    osd_regaccess_responder_if.slave bus
);

    // Everything below the host window is read-only; only the three id words exist.
    assign bus.ext   = bus.addr >= ADDR_EXT_BASE;
    assign bus.err   = bus.write || bus.addr > ADDR_VERSION;
    assign bus.rdata = bus.addr == ADDR_VENDOR  ? MOD_VENDOR  :
                       bus.addr == ADDR_TYPE    ? MOD_TYPE    :
                       bus.addr == ADDR_VERSION ? MOD_VERSION : 16'h0000;

endmodule

// File: rtl/osd_regaccess_responder.sv
// osd_regaccess_responder: DII register-access request parser, host access and response framer.
// Optional access timeout enabled by defining OSD_REGACCESS_TIMEOUT_EN.
module osd_regaccess_responder
    import dii_package::*;
#(
    parameter logic [15:0] MOD_VENDOR     = 16'h0,
    parameter logic [15:0] MOD_TYPE       = 16'h0,
    parameter logic [15:0] MOD_VERSION    = 16'h0,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] id,
    input  dii_flit     debug_in,
    output logic        debug_in_ready,
    output dii_flit     debug_out,
    input  logic        debug_out_ready,
    output logic        reg_request,
    output logic        reg_write,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wdata,
    input  logic        reg_ack,
    input  logic        reg_err,
    input  logic [15:0] reg_rdata
);

    state_t      state, state_nx;
    logic [15:0] src_q, addr_q, wdata_q, rdata_q;
    logic        write_q, err_q, drain_resp_q;
    logic        in_fire, out_fire, type_ok, final_flit, timeout, done;
    logic [3:0]  resp_sub;

    osd_regaccess_responder_if bif();

    osd_regaccess_baseregs #(
        .MOD_VENDOR  (MOD_VENDOR),
        .MOD_TYPE    (MOD_TYPE),
        .MOD_VERSION (MOD_VERSION)
    ) u_baseregs (
        .bus (bif.slave)
    );

    // Reads decode the address flit as it arrives; writes decode the latched address.
    assign bif.addr  = state == RX_ADDR ? debug_in.data : addr_q;
    assign bif.write = write_q;

    assign in_fire    = debug_in.valid && debug_in_ready;
    assign out_fire   = debug_out.valid && debug_out_ready;
    assign type_ok    = debug_in.data[15:14] == TYPE_REG && debug_in.data[13:10] <= REQ_WRITE;
    assign final_flit = state == RX_WDATA || (state == RX_ADDR && !write_q);
    assign done       = reg_ack || reg_err || timeout;

`ifdef OSD_REGACCESS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= state == ACCESS ? cnt + 1'b1 : '0;
    end
    assign timeout = state == ACCESS && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (in_fire && !debug_in.last) state_nx = RX_SRC;
            RX_SRC:   if (in_fire) state_nx = debug_in.last ? IDLE : RX_TYPE;
            RX_TYPE:  if (in_fire) state_nx = debug_in.last ? IDLE : type_ok ? RX_ADDR : DRAIN;
            RX_ADDR:  if (in_fire) state_nx = write_q ? (debug_in.last ? IDLE : RX_WDATA) :
                                              !debug_in.last ? DRAIN : bif.ext ? ACCESS : TX_DEST;
            RX_WDATA: if (in_fire) state_nx = !debug_in.last ? DRAIN : bif.ext ? ACCESS : TX_DEST;
            DRAIN:    if (in_fire && debug_in.last) state_nx = drain_resp_q ? TX_DEST : IDLE;
            ACCESS:   if (done) state_nx = TX_DEST;
            TX_DEST:  if (out_fire) state_nx = TX_SRC;
            TX_SRC:   if (out_fire) state_nx = TX_TYPE;
            TX_TYPE:  if (out_fire) state_nx = write_q ? IDLE : TX_RDATA;
            TX_RDATA: if (out_fire) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            drain_resp_q <= 1'b0;
        end else begin
            if (in_fire && state == RX_SRC) src_q <= debug_in.data;
            if (in_fire && state == RX_TYPE) begin
                write_q      <= debug_in.data[13:10] == REQ_WRITE;
                drain_resp_q <= 1'b0;
            end
            if (in_fire && state == RX_ADDR) addr_q <= debug_in.data;
            if (in_fire && state == RX_WDATA) wdata_q <= debug_in.data;
            // A missing last turns the packet into an error response after draining.
            if (in_fire && final_flit) begin
                err_q        <= !debug_in.last || bif.err;
                rdata_q      <= (!debug_in.last || bif.err) ? 16'h0000 : bif.rdata;
                drain_resp_q <= !debug_in.last;
            end
            if (state == ACCESS && done) begin
                err_q   <= reg_err || !reg_ack;
                rdata_q <= (reg_ack && !reg_err) ? reg_rdata : 16'h0000;
            end
        end
    end

    always_comb begin
        resp_sub        = write_q ? (err_q ? RESP_WRITE_ERR : RESP_WRITE_OK) :
                                    (err_q ? RESP_READ_ERR : RESP_READ_OK);
        debug_in_ready  = rst_n && state inside {IDLE, RX_SRC, RX_TYPE, RX_ADDR, RX_WDATA, DRAIN};
        reg_request     = state == ACCESS;
        reg_write       = reg_request && write_q;
        reg_addr        = reg_request ? addr_q : 16'h0000;
        reg_wdata       = reg_write ? wdata_q : 16'h0000;
        debug_out.valid = state inside {TX_DEST, TX_SRC, TX_TYPE, TX_RDATA};
        debug_out.last  = state == TX_RDATA || (state == TX_TYPE && write_q);
        debug_out.data  = state == TX_DEST  ? src_q :
                          state == TX_SRC   ? id :
                          state == TX_TYPE  ? type_word(resp_sub) :
                          state == TX_RDATA ? rdata_q : 16'h0000;
    end

endmodule

// File: tb/tb_osd_regaccess_responder.sv
// tb_osd_regaccess_responder: directed tests of request parsing, host access and response framing.
module tb_osd_regaccess_responder;
    import dii_package::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] id = 16'd3;
    dii_flit     din, dout;
    logic        din_ready, dout_ready;
    logic        reg_request, reg_write, reg_ack, reg_err;
    logic [15:0] reg_addr, reg_wdata, reg_rdata;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    osd_regaccess_responder #(
        .MOD_VENDOR     (16'h1234),
        .MOD_TYPE       (16'h0042),
        .MOD_VERSION    (16'h0007),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id              (id),
        .debug_in        (din),
        .debug_in_ready  (din_ready),
        .debug_out       (dout),
        .debug_out_ready (dout_ready),
        .reg_request     (reg_request),
        .reg_write       (reg_write),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_ack         (reg_ack),
        .reg_err         (reg_err),
        .reg_rdata       (reg_rdata)
    );

    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        din = '{valid: 1'b1, last: l, data: d};
        while (!din_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready: ready=%b required 1", din_ready);
        end
        @(posedge clk);
        #1 din.valid = 1'b0;
    endtask

    task automatic req(input logic [15:0] s, input logic w, input logic [15:0] a, input logic [15:0] wd);
        send(16'd3, 1'b0);
        send(s, 1'b0);
        send(w ? 16'h0400 : 16'h0000, 1'b0);
        if (w) begin
            send(a, 1'b0);
            send(wd, 1'b1);
        end else send(a, 1'b1);
    endtask

    task automatic recv(input logic [15:0] d, input logic l, input int stall, input string nm);
        int n = 0;
        dout_ready = 1'b0;
        @(negedge clk);
        while (!dout.valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!dout.valid) begin
            errors++;
            $display("FAIL %s_valid: valid=%b required 1", nm, dout.valid);
            return;
        end
        for (int i = 0; i < stall; i++) begin
            checks++;
            if (dout.valid !== 1'b1 || dout.data !== d || dout.last !== l) begin
                errors++;
                $display("FAIL %s_stall: valid=%b data=%h last=%b required 1 %h %b", nm, dout.valid, dout.data, dout.last, d, l);
            end
            @(negedge clk);
        end
        checks++;
        if (dout.data !== d || dout.last !== l) begin
            errors++;
            $display("FAIL %s: data=%h last=%b required data=%h last=%b", nm, dout.data, dout.last, d, l);
        end
        dout_ready = 1'b1;
        @(posedge clk);
        #1 dout_ready = 1'b0;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        @(negedge clk);
        while (!reg_request && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!reg_request) begin
            errors++;
            $display("FAIL %s_request: reg_request=%b required 1", nm, reg_request);
        end
    endtask

    task automatic quiet(input int cycles, input string nm);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | dout.valid | reg_request;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL %s_quiet: activity=%b required 0", nm, seen);
        end
    endtask

    task automatic test_reset;
        din = '{valid: 1'b0, last: 1'b0, data: 16'h0};
        dout_ready = 1'b0;
        reg_ack = 1'b0;
        reg_err = 1'b0;
        reg_rdata = 16'h0;
        rst_n = 1'b0;
        #3;
        checks += 3;
        if (dout.valid !== 1'b0 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: valid=%b ready=%b required 0 0", dout.valid, din_ready);
        end
        if (reg_request !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: request=%b write=%b required 0 0", reg_request, reg_write);
        end
        if (reg_addr !== 16'h0 || reg_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h required 0 0", reg_addr, reg_wdata);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready: ready=%b required 1", din_ready);
        end
    endtask

    task automatic test_internal_read;
        req(16'd5, 1'b0, 16'h0001, 16'h0);
        @(negedge clk);
        checks++;
        if (dout.valid !== 1'b1 || dout.data !== 16'd5) begin
            errors++;
            $display("FAIL int_latency: valid=%b data=%h required 1 0005", dout.valid, dout.data);
        end
        recv(16'd5, 1'b0, 0, "int_dest");
        recv(16'd3, 1'b0, 0, "int_src");
        recv(16'h0800, 1'b0, 0, "int_type");
        recv(16'h0042, 1'b1, 0, "int_data");
        req(16'd7, 1'b0, 16'h0000, 16'h0);
        recv(16'd7, 1'b0, 0, "vendor_dest");
        recv(16'd3, 1'b0, 0, "vendor_src");
        recv(16'h0800, 1'b0, 0, "vendor_type");
        recv(16'h1234, 1'b1, 0, "vendor_data");
    endtask

    task automatic test_internal_err;
        req(16'd5, 1'b0, 16'h0003, 16'h0);
        recv(16'd5, 1'b0, 0, "rd3_dest");
        recv(16'd3, 1'b0, 0, "rd3_src");
        recv(16'h0C00, 1'b0, 0, "rd3_type");
        recv(16'h0000, 1'b1, 0, "rd3_data");
        req(16'd5, 1'b0, 16'h01FF, 16'h0);
        recv(16'd5, 1'b0, 0, "rd1ff_dest");
        recv(16'd3, 1'b0, 0, "rd1ff_src");
        recv(16'h0C00, 1'b0, 0, "rd1ff_type");
        recv(16'h0000, 1'b1, 0, "rd1ff_data");
        req(16'd8, 1'b1, 16'h0000, 16'h5555);
        recv(16'd8, 1'b0, 0, "wr0_dest");
        recv(16'd3, 1'b0, 0, "wr0_src");
        recv(16'h1400, 1'b1, 0, "wr0_type");
    endtask

    task automatic test_ext_write;
        req(16'd9, 1'b1, 16'h0210, 16'hBEEF);
        @(negedge clk);
        checks++;
        if (reg_request !== 1'b1 || reg_write !== 1'b1 || reg_addr !== 16'h0210 || reg_wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL ext_wr_bus: req=%b wr=%b addr=%h wdata=%h required 1 1 0210 beef",
                     reg_request, reg_write, reg_addr, reg_wdata);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (reg_request !== 1'b1 || reg_addr !== 16'h0210 || reg_wdata !== 16'hBEEF) begin
                errors++;
                $display("FAIL ext_wr_hold: req=%b addr=%h wdata=%h required 1 0210 beef", reg_request, reg_addr, reg_wdata);
            end
        end
        reg_ack = 1'b1;
        @(posedge clk);
        #1 reg_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_request !== 1'b0 || dout.valid !== 1'b1) begin
            errors++;
            $display("FAIL ext_wr_done: req=%b valid=%b required 0 1", reg_request, dout.valid);
        end
        recv(16'd9, 1'b0, 0, "ext_wr_dest");
        recv(16'd3, 1'b0, 0, "ext_wr_src");
        recv(16'h1000, 1'b1, 0, "ext_wr_type");
    endtask

    task automatic ext_read(input logic [15:0] a, input logic ack, input logic err, input logic [15:0] rd,
                            input logic [15:0] t, input logic [15:0] d, input string nm);
        req(16'd4, 1'b0, a, 16'h0);
        wait_req(nm);
        checks++;
        if (reg_write !== 1'b0 || reg_addr !== a) begin
            errors++;
            $display("FAIL %s_bus: wr=%b addr=%h required 0 %h", nm, reg_write, reg_addr, a);
        end
        reg_ack = ack;
        reg_err = err;
        reg_rdata = rd;
        @(posedge clk);
        #1;
        reg_ack = 1'b0;
        reg_err = 1'b0;
        reg_rdata = 16'h0;
        recv(16'd4, 1'b0, 0, {nm, "_dest"});
        recv(16'd3, 1'b0, 0, {nm, "_src"});
        recv(t, 1'b0, 0, {nm, "_type"});
        recv(d, 1'b1, 0, {nm, "_data"});
    endtask

    task automatic test_ext_read;
        ext_read(16'h0300, 1'b0, 1'b1, 16'h9999, 16'h0C00, 16'h0000, "ext_rd_err");
        ext_read(16'h0400, 1'b1, 1'b0, 16'hCAFE, 16'h0800, 16'hCAFE, "ext_rd_ok");
        ext_read(16'h0500, 1'b1, 1'b1, 16'h1111, 16'h0C00, 16'h0000, "ext_rd_both");
    endtask

    task automatic test_malformed;
        send(16'd3, 1'b0);
        send(16'd5, 1'b0);
        send(16'h0000, 1'b1);
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1 || dout.valid !== 1'b0) begin
            errors++;
            $display("FAIL short_drop: ready=%b valid=%b required 1 0", din_ready, dout.valid);
        end
        send(16'd3, 1'b0);
        send(16'd5, 1'b0);
        send(16'h1C00, 1'b0);
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b0);
        send(16'hCCCC, 1'b1);
        quiet(6, "drain_sub7");
        send(16'd3, 1'b0);
        send(16'd5, 1'b0);
        send(16'h0400, 1'b0);
        send(16'h0210, 1'b1);
        quiet(6, "write_early_last");
        send(16'd3, 1'b0);
        send(16'd5, 1'b0);
        send(16'h0000, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h0055, 1'b1);
        recv(16'd5, 1'b0, 0, "nolast_rd_dest");
        recv(16'd3, 1'b0, 0, "nolast_rd_src");
        recv(16'h0C00, 1'b0, 0, "nolast_rd_type");
        recv(16'h0000, 1'b1, 0, "nolast_rd_data");
        send(16'd3, 1'b0);
        send(16'd6, 1'b0);
        send(16'h0400, 1'b0);
        send(16'h0210, 1'b0);
        send(16'hBEEF, 1'b0);
        send(16'h0077, 1'b1);
        recv(16'd6, 1'b0, 0, "nolast_wr_dest");
        recv(16'd3, 1'b0, 0, "nolast_wr_src");
        recv(16'h1400, 1'b1, 0, "nolast_wr_type");
    endtask

    task automatic test_backpressure;
        req(16'd6, 1'b0, 16'h0002, 16'h0);
        recv(16'd6, 1'b0, 0, "bp_dest");
        recv(16'd3, 1'b0, 10, "bp_src");
        recv(16'h0800, 1'b0, 0, "bp_type");
        recv(16'h0007, 1'b1, 0, "bp_data");
        @(negedge clk);
        checks++;
        if (dout.valid !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_end: valid=%b ready=%b required 0 1", dout.valid, din_ready);
        end
    endtask

    task automatic test_reset_mid_access;
        req(16'd5, 1'b0, 16'h0600, 16'h0);
        wait_req("rst_mid");
        rst_n = 1'b0;
        #1;
        checks++;
        if (reg_request !== 1'b0 || reg_addr !== 16'h0 || dout.valid !== 1'b0 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: req=%b addr=%h valid=%b ready=%b required 0 0000 0 0",
                     reg_request, reg_addr, dout.valid, din_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (din_ready !== 1'b1 || reg_request !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: ready=%b req=%b required 1 0", din_ready, reg_request);
        end
        req(16'd2, 1'b0, 16'h0001, 16'h0);
        recv(16'd2, 1'b0, 0, "rst_after_dest");
        recv(16'd3, 1'b0, 0, "rst_after_src");
        recv(16'h0800, 1'b0, 0, "rst_after_type");
        recv(16'h0042, 1'b1, 0, "rst_after_data");
    endtask

`ifdef OSD_REGACCESS_TIMEOUT_EN
    task automatic test_timeout;
        int n = 0;
        req(16'd5, 1'b0, 16'h0700, 16'h0);
        @(negedge clk);
        while (reg_request && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_cycles: request_cycles=%0d required 16", n);
        end
        recv(16'd5, 1'b0, 0, "to_dest");
        recv(16'd3, 1'b0, 0, "to_src");
        recv(16'h0C00, 1'b0, 0, "to_type");
        recv(16'h0000, 1'b1, 0, "to_data");
    endtask
`endif

    initial begin
        test_reset();
        test_internal_read();
        test_internal_err();
        test_ext_write();
        test_ext_read();
        test_malformed();
        test_backpressure();
        test_reset_mid_access();
`ifdef OSD_REGACCESS_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/osd_regaccess_responder.md
OSD_REGACCESS_RESPONDER -- requirements
Module: osd_regaccess_responder

Interface
REQ-001 SHALL have parameters: MOD_VENDOR (16'h0), module vendor ID; MOD_TYPE (16'h0), module type ID; MOD_VERSION (16'h0), module version; TIMEOUT_CYCLES (256), register-access timeout.
REQ-002 SHALL have ports (name direction width meaning), one clock, reset asynchronous and active-low:
  clk  in  1  sole clock.
  rst_n  in  1  asynchronous active-low reset.
  id  in  16  own ring address.
  debug_in  in  dii_flit  request flits from ring port (valid, last, data[15:0]).
  debug_in_ready  out  1  request flit accepted.
  debug_out  out  dii_flit  response flits to ring port.
  debug_out_ready  in  1  ring accepts response flit.
  reg_request  out  1  host register access pending.
  reg_write  out  1  1=write, 0=read.
  reg_addr  out  16  host register address.
  reg_wdata  out  16  host write data.
  reg_ack  in  1  host access done, success.
  reg_err  in  1  host access done, error.
  reg_rdata  in  16  host read data, valid with reg_ack.

Function
REQ-003 Packet flits SHALL be: dest, src, type word, payload; type[15:14]=2'b00 (REG), type[13:10] subtype: 0 REQ_READ, 1 REQ_WRITE, 2 RESP_READ_OK, 3 RESP_READ_ERR, 4 RESP_WRITE_OK, 5 RESP_WRITE_ERR.
REQ-004 Flit transfer SHALL occur only on valid && ready; debug_in_ready SHALL be 1 only in receive/drain states, 0 otherwise.
REQ-005 FSM states SHALL be IDLE, RX_SRC, RX_TYPE, RX_ADDR, RX_WDATA, DRAIN, ACCESS, TX_DEST, TX_SRC, TX_TYPE, TX_RDATA.
REQ-006 IDLE->RX_SRC on dest flit; RX_SRC latches src; RX_TYPE latches subtype; READ expects exactly addr (last on addr), WRITE expects addr then wdata (last on wdata).
REQ-007 last seen before expected payload complete SHALL drop the packet silently, return to IDLE, no response.
REQ-008 Non-REG type or subtype not in {0,1} SHALL go to DRAIN until last accepted, then IDLE, no response.
REQ-009 Expected final flit without last SHALL enter DRAIN and then send the matching *_ERR response.
REQ-010 Addresses 0x0000/0x0001/0x0002 SHALL read MOD_VENDOR/MOD_TYPE/MOD_VERSION internally, no host access; writes to 0x0000-0x01FF and reads of 0x0003-0x01FF SHALL yield *_ERR.
REQ-011 Addresses >=0x0200 SHALL go to ACCESS: reg_request=1 with reg_write/reg_addr/reg_wdata stable until the cycle reg_ack or reg_err is sampled 1; reg_request deasserts next cycle.
REQ-012 reg_ack and reg_err both 1 SHALL be treated as error.
REQ-013 Response SHALL be: dest=latched src, src=id, type word, then read data for RESP_READ_OK/ERR (4 flits, ERR data 16'h0); write responses SHALL be 3 flits, last on type word.
REQ-014 First response flit SHALL be valid the cycle after ACCESS completes (or after final request flit for internal addresses); debug_out SHALL hold stable while valid && !debug_out_ready.
REQ-015 After last response flit accepted SHALL return to IDLE; one request outstanding at a time (no pipelining).

Reset
REQ-016 rst_n low SHALL immediately force IDLE; debug_out.valid=0, debug_in_ready=0, reg_request=0, reg_write=0, reg_addr=0, reg_wdata=0; partial packets in flight are discarded.

Configuration
REQ-017 With OSD_REGACCESS_TIMEOUT_EN defined, a counter SHALL start on ACCESS entry; reaching TIMEOUT_CYCLES without reg_ack/reg_err SHALL drop reg_request and send *_ERR. Without it, ACCESS SHALL wait indefinitely and no counter exists.

Structure
REQ-018 Type/subtype encodings and base register addresses SHALL live in dii_package beside dii_flit.
REQ-019 Base-register decode (REQ-010) SHALL be sub-module osd_regaccess_baseregs; FSM and framing stay in the top module.

Verification
REQ-020 id=3; read addr 0x0001, MOD_TYPE=16'h0042, src 5 -> flits {5,3,0x0800,0x0042}, last on 4th.
REQ-021 Write addr 0x0210 data 0xBEEF -> reg_request, reg_write=1, reg_addr=0x0210, reg_wdata=0xBEEF; ack after 3 cycles -> {src,3,0x1000} last on 3rd.
REQ-022 Read 0x0300, reg_err pulse -> {src,3,0x0C00,0x0000}.
REQ-023 Read packet with last on type flit -> no response, debug_in_ready high next request; unknown subtype 7 of 6 flits drained, no response.
REQ-024 debug_out_ready held low 10 cycles mid-response -> flits stable, none lost or duplicated; rst_n low mid-ACCESS -> reg_request=0 immediately, IDLE.
REQ-025 OSD_REGACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> reg_request drops after 16 cycles, RESP_READ_ERR sent.
